// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core's data port and one auxiliary master.
// Fixed cpu priority from idle, alternation on contention, and a bounded aux burst.
module dmem_arbiter #(
   parameter int unsigned Dbits = 32,
   parameter int unsigned Abits = 32,
   parameter int unsigned BURST = 4
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             cpu_req,
   input  logic             cpu_wr,
   input  logic [Abits-1:0] cpu_addr,
   input  logic [Dbits-1:0] cpu_wdata,
   output logic             cpu_gnt,
   output logic             cpu_stall,
   output logic             cpu_rvalid,
   output logic [Dbits-1:0] cpu_rdata,

   input  logic             aux_req,
   input  logic             aux_wr,
   input  logic [Abits-1:0] aux_addr,
   input  logic [Dbits-1:0] aux_wdata,
   output logic             aux_gnt,
   output logic             aux_rvalid,
   output logic [Dbits-1:0] aux_rdata,

   output logic             mem_en,
   output logic             mem_wr,
   output logic [Abits-1:0] mem_addr,
   output logic [Dbits-1:0] mem_wdata,
   input  logic [Dbits-1:0] mem_rdata
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCpu  = 2'd1;
   localparam logic [1:0] StAux  = 2'd2;

   localparam logic [3:0] BurstLim = 4'(BURST);
   localparam logic [3:0] CntMax   = 4'hF;

   logic [1:0] owner_q, owner_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cpu_rvalid_q, cpu_rvalid_d;
   logic       aux_rvalid_q, aux_rvalid_d;
   logic       cpu_gnt_c, aux_gnt_c;

   // Grants are suppressed while reset is held so nothing reaches memory.
   always_comb begin
      cpu_gnt_c = 1'b0;
      aux_gnt_c = 1'b0;
      if (reset) begin
         if (cpu_req && !aux_req) begin
            cpu_gnt_c = 1'b1;
         end else if (aux_req && !cpu_req) begin
            aux_gnt_c = 1'b1;
         end else if (cpu_req && aux_req) begin
            case (owner_q)
               StIdle:  cpu_gnt_c = 1'b1;
               StCpu:   aux_gnt_c = 1'b1;
               StAux: begin
                  if (cnt_q < BurstLim) begin
                     aux_gnt_c = 1'b1;
                  end else begin
                     cpu_gnt_c = 1'b1;
                  end
               end
               default: cpu_gnt_c = 1'b1;
            endcase
         end
      end
   end

   always_comb begin
      owner_d = StIdle;
      cnt_d   = 4'd0;
      if (cpu_gnt_c) begin
         owner_d = StCpu;
      end else if (aux_gnt_c) begin
         owner_d = StAux;
         cnt_d   = (cnt_q == CntMax) ? CntMax : cnt_q + 4'd1;
      end
   end

   assign cpu_rvalid_d = cpu_gnt_c & ~cpu_wr;
   assign aux_rvalid_d = aux_gnt_c & ~aux_wr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q      <= StIdle;
         cnt_q        <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         aux_rvalid_q <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         aux_rvalid_q <= aux_rvalid_d;
      end
   end

   always_comb begin
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt_c) begin
         mem_wr    = cpu_wr;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (aux_gnt_c) begin
         mem_wr    = aux_wr;
         mem_addr  = aux_addr;
         mem_wdata = aux_wdata;
      end
   end

   assign mem_en     = cpu_gnt_c | aux_gnt_c;
   assign cpu_gnt    = cpu_gnt_c;
   assign aux_gnt    = aux_gnt_c;
   assign cpu_stall  = reset & cpu_req & ~cpu_gnt_c;
   assign cpu_rvalid = cpu_rvalid_q;
   assign aux_rvalid = aux_rvalid_q;
   assign cpu_rdata  = mem_rdata;
   assign aux_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model and a read-return scoreboard.
module tb_dmem_arbiter;

   localparam int unsigned Dbits = 32;
   localparam int unsigned Abits = 32;

   logic             clk;
   logic             reset;
   logic             cpu_req, cpu_wr, aux_req, aux_wr;
   logic [Abits-1:0] cpu_addr, aux_addr;
   logic [Dbits-1:0] cpu_wdata, aux_wdata;
   logic             cpu_gnt, cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
   logic [Dbits-1:0] cpu_rdata, aux_rdata;
   logic             mem_en, mem_wr;
   logic [Abits-1:0] mem_addr;
   logic [Dbits-1:0] mem_wdata, mem_rdata;

   typedef struct {
      logic        is_cpu;
      logic [31:0] data;
      int          cyc;
   } ret_t;

   ret_t        sb[$];
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   int          cyc;
   int          checks;
   int          errors;

   dmem_arbiter #(.Dbits(Dbits), .Abits(Abits), .BURST(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .aux_req    (aux_req),
      .aux_wr     (aux_wr),
      .aux_addr   (aux_addr),
      .aux_wdata  (aux_wdata),
      .aux_gnt    (aux_gnt),
      .aux_rvalid (aux_rvalid),
      .aux_rdata  (aux_rdata),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory standing in for the real data memory.
   always @(posedge clk) begin
      if (mem_en && !mem_wr) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_en && mem_wr)  mem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_cpu(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
      cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
   endtask

   task automatic set_aux(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
      aux_req = req; aux_wr = wr; aux_addr = addr; aux_wdata = wdata;
   endtask

   // Waits for the falling edge, checks this cycle's outputs and records expected returns.
   task automatic check_comb(input string tag, input logic exp_cg, input logic exp_ag);
      logic        exp_cv, exp_av;
      logic [31:0] exp_d, exp_addr, exp_wd;
      logic        exp_wr;
      @(negedge clk);
      exp_cv = 1'b0;
      exp_av = 1'b0;
      exp_d  = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_cv = sb[0].is_cpu;
         exp_av = ~sb[0].is_cpu;
         exp_d  = sb[0].data;
         void'(sb.pop_front());
      end
      chk({tag, ".cpu_rvalid"}, 64'(cpu_rvalid), 64'(exp_cv));
      chk({tag, ".aux_rvalid"}, 64'(aux_rvalid), 64'(exp_av));
      if (exp_cv) chk({tag, ".cpu_rdata"}, 64'(cpu_rdata), 64'(exp_d));
      if (exp_av) chk({tag, ".aux_rdata"}, 64'(aux_rdata), 64'(exp_d));

      exp_wr   = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      if (exp_cg) begin
         exp_wr = cpu_wr; exp_addr = cpu_addr; exp_wd = cpu_wdata;
      end else if (exp_ag) begin
         exp_wr = aux_wr; exp_addr = aux_addr; exp_wd = aux_wdata;
      end
      chk({tag, ".cpu_gnt"},   64'(cpu_gnt),   64'(exp_cg));
      chk({tag, ".aux_gnt"},   64'(aux_gnt),   64'(exp_ag));
      chk({tag, ".cpu_stall"}, 64'(cpu_stall), 64'(reset & cpu_req & ~exp_cg));
      chk({tag, ".mem_en"},    64'(mem_en),    64'(exp_cg | exp_ag));
      chk({tag, ".mem_wr"},    64'(mem_wr),    64'(exp_wr));
      chk({tag, ".mem_addr"},  64'(mem_addr),  64'(exp_addr));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(exp_wd));

      if ((exp_cg || exp_ag) && exp_wr) begin
         ref_mem[exp_addr[7:0]] = exp_wd;
      end else if (exp_cg || exp_ag) begin
         sb.push_back('{is_cpu: exp_cg, data: ref_mem[exp_addr[7:0]], cyc: cyc + 1});
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cycle(input string tag, input logic exp_cg, input logic exp_ag);
      check_comb(tag, exp_cg, exp_ag);
      next_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA500_0000 | 32'(i);
         ref_mem[i] = 32'hA500_0000 | 32'(i);
      end
      mem[8'h10]     = 32'hDEAD_BEEF;
      ref_mem[8'h10] = 32'hDEAD_BEEF;
      mem_rdata      = '0;

      // Reset held with both masters requesting.
      reset = 1'b0;
      set_cpu(1'b1, 1'b0, 32'h30, 32'h0);
      set_aux(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      check_cycle("rst0", 1'b0, 1'b0);
      check_cycle("rst1", 1'b0, 1'b0);

      // Release: idle tie goes to cpu, then bursts of four aux grants.
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         set_cpu(1'b1, 1'b0, 32'h30 + 32'(k), 32'h0);
         set_aux(1'b1, 1'b0, 32'h40 + 32'(k), 32'h0);
         check_cycle($sformatf("cont%0d", k), (k % 5) == 0, (k % 5) != 0);
      end

      // Lone cpu read.
      set_aux(1'b0, 1'b0, 32'h0, 32'h0);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      check_cycle("cpurd", 1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      check_cycle("cpurd_ret", 1'b0, 1'b0);

      // Aux write while cpu idle, then read it back through the cpu.
      set_aux(1'b1, 1'b1, 32'h20, 32'h55);
      check_cycle("auxwr", 1'b0, 1'b1);
      set_aux(1'b0, 1'b0, 32'h0, 32'h0);
      check_cycle("auxwr_idle", 1'b0, 1'b0);
      set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
      check_cycle("rdback", 1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      check_cycle("rdback_ret", 1'b0, 1'b0);

      // Alternating lone requests.
      set_cpu(1'b1, 1'b0, 32'h11, 32'h0);
      check_cycle("alt0", 1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_aux(1'b1, 1'b0, 32'h12, 32'h0);
      check_cycle("alt1", 1'b0, 1'b1);
      set_aux(1'b0, 1'b0, 32'h0, 32'h0);
      set_cpu(1'b1, 1'b0, 32'h13, 32'h0);
      check_cycle("alt2", 1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      check_cycle("alt3", 1'b0, 1'b0);
      check_cycle("alt4", 1'b0, 1'b0);

      // Cpu read granted, then reset spans the return edge.
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      check_comb("rpulse_gnt", 1'b1, 1'b0);
      #1;
      reset = 1'b0;
      sb.delete();
      next_cycle();
      set_aux(1'b1, 1'b0, 32'h44, 32'h0);
      check_cycle("rpulse_low", 1'b0, 1'b0);
      reset = 1'b1;
      check_cycle("rpulse_rel", 1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_aux(1'b0, 1'b0, 32'h0, 32'h0);
      check_cycle("rpulse_ret", 1'b0, 1'b0);
      check_cycle("final", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the MIPS core's data port (cpu) and one auxiliary bus master (aux, e.g. DMA or display fetch).
- Grants at most one access per cycle, using CPU priority, alternation on contention and a bounded aux burst.
- Produces a stall for the core and returns synchronous-read data tagged to the winning requester one cycle later.
- Sits between the mips top level and the data memory.

Parameters:
Dbits, 32, data word width
Abits, 32, address width
BURST, 4, max consecutive aux grants while cpu is waiting (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cpu_req  input  1  cpu access request; level, held until granted
cpu_wr  input  1  1=write, 0=read; valid with cpu_req
cpu_addr  input  Abits  cpu address
cpu_wdata  input  Dbits  cpu write data
cpu_gnt  output  1  cpu request accepted this cycle
cpu_stall  output  1  cpu_req & ~cpu_gnt; drives core enable low
cpu_rvalid  output  1  cpu read data valid
cpu_rdata  output  Dbits  cpu read data
aux_req  input  1  aux access request
aux_wr  input  1  aux write strobe
aux_addr  input  Abits  aux address
aux_wdata  input  Dbits  aux write data
aux_gnt  output  1  aux request accepted this cycle
aux_rvalid  output  1  aux read data valid
aux_rdata  output  Dbits  aux read data
mem_en  output  1  memory access this cycle
mem_wr  output  1  memory write enable
mem_addr  output  Abits  memory address
mem_wdata  output  Dbits  memory write data
mem_rdata  input  Dbits  memory read data, 1-cycle synchronous latency

Behaviour:
- Registered state: owner FSM {IDLE, CPU, AUX}, 4-bit aux beat counter cnt, cpu_rvalid, aux_rvalid.
- Reset (reset=0, async): owner=IDLE, cnt=0, both rvalid=0. While reset=0: cpu_gnt=aux_gnt=0, mem_en=0, mem_wr=0, cpu_stall=0.
- Grants are combinational from req and registered state; at most one grant high per cycle.
- Single requester: it is granted immediately, in any state.
- Tie (both req):
  - IDLE: grant cpu.
  - CPU: grant aux.
  - AUX: grant aux if cnt<BURST, else cpu.
- Next state:
  - cpu_gnt -> CPU, cnt=0.
  - aux_gnt -> AUX, cnt=sat(cnt+1), where cnt+1 saturates at 15.
  - no grant -> IDLE, cnt=0.
- Memory mux: mem_en=cpu_gnt|aux_gnt. mem_wr/mem_addr/mem_wdata follow the granted requester. mem_wr=0 when mem_en=0. mem_addr/mem_wdata=0 when idle.
- Read return: cpu_rvalid <= cpu_gnt & ~cpu_wr, and likewise for aux. Exactly 1 cycle after a read grant.
- rdata outputs: cpu_rdata=aux_rdata=mem_rdata, unregistered. Meaningful only when the matching rvalid=1.
- Writes complete on the grant cycle; no rvalid is produced for a write.
- Requester may change wr/addr/wdata in the cycle after its grant. Back-to-back grants to the same requester are legal, giving full throughput.
- Worst-case cpu wait: BURST cycles. Worst-case aux wait while the cpu streams: 1 cycle.
- Reset asserted mid-operation: pending rvalid cleared, so no return is issued for a read granted in the cycle before reset.

Test Plan:
- Reset held 0 with both req=1 -> both gnt=0, mem_en=0, rvalid=0. Release -> cpu_gnt=1 first cycle (IDLE tie).
- cpu read at addr 0x10 alone, memory returns 0xDEADBEEF -> cpu_gnt=1, cpu_stall=0, mem_addr=0x10, mem_wr=0. Next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, aux_rvalid=0.
- cpu and aux both request continuously, starting from IDLE, BURST=4 -> grant sequence cpu, aux, aux, aux, aux, cpu, aux, aux, aux, aux… cpu_stall=1 exactly on the aux-grant cycles.
- aux write 0x55 to 0x20 while cpu idle -> mem_en=1, mem_wr=1, mem_addr=0x20, mem_wdata=0x55. No rvalid follows.
- cpu read granted, reset pulsed low for one cycle before the return edge -> cpu_rvalid stays 0 and owner returns to IDLE.
- Alternating single requests (cpu, aux, cpu on successive cycles) -> each granted the same cycle with zero stall. Each read's rvalid appears only on its own requester one cycle later.
